// File: rtl/blk_mem_responder_pkg.sv
// Shared cache package: block geometry, request/response structs and the
// block-memory responder state type and default constants.
package blk_mem_responder_pkg;

  // Block geometry shared by the cache and its backing memory.
  localparam int WORD_WIDTH   = 32;
  localparam int ADDR_WIDTH   = 32;
  localparam int BLOCK_SIZE   = 4;
  localparam int OFFSET_WIDTH = $clog2(BLOCK_SIZE);

  // Backing-memory defaults.
  localparam int MEM_LATENCY  = 4;
  localparam int MEM_WORDS    = 4096;

  typedef logic [WORD_WIDTH-1:0] word_t;
  typedef word_t [BLOCK_SIZE-1:0] block_t;

  // Block request issued by the cache toward memory.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  cs;
    logic                  rw;
    block_t                data;
  } memory_request_t;

  // Memory reply to the cache.
  typedef struct packed {
    logic   ack;
    block_t data;
  } memory_response_t;

  // Responder FSM states.
  typedef enum logic [1:0] {
    bm_idle,
    bm_wait,
    bm_ack
  } blk_mem_state_t;

  // Word address of the first word of the block containing addr.
  function automatic logic [ADDR_WIDTH-1:0] block_base(input logic [ADDR_WIDTH-1:0] addr);
    return {addr[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
  endfunction

endpackage

// File: rtl/blk_mem_array.sv
// Block-wide storage: BLOCK_SIZE word banks sharing one block index, so a
// whole block is read or written in a single clock. Read data is registered
// and holds between reads. Contents are never reset.
module blk_mem_array
  import blk_mem_responder_pkg::*;
#(
  parameter int  DEPTH_WORDS = 4096,
  localparam int NUM_BLOCKS  = DEPTH_WORDS / BLOCK_SIZE,
  localparam int IDX_WIDTH   = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [IDX_WIDTH-1:0] blk_idx,
  input  block_t               wdata,
  output block_t               rdata
);

  // One bank per word lane; word gi of every block lives in bank gi.
  for (genvar gi = 0; gi < BLOCK_SIZE; gi++) begin : g_bank
    word_t bank_mem [NUM_BLOCKS];
    word_t rd_reg;

    // Single port per bank: write on we, otherwise registered read.
    always_ff @(posedge clk) begin
      if (en) begin
        if (we) begin
          bank_mem[blk_idx] <= wdata[gi];
        end else begin
          rd_reg <= bank_mem[blk_idx];
        end
      end
    end

    assign rdata[gi] = rd_reg;
  end

endmodule

// File: rtl/blk_mem_responder.sv
// Block memory responder: accepts one block request at a time from the cache,
// waits LATENCY cycles, then commits a write or returns read data with a
// one-cycle ack.
// Optional build macro BLK_MEM_RANGE_CHECK_EN: out-of-range blocks are
// reported on a sticky err flag instead of wrapping modulo MEM_WORDS.
module blk_mem_responder
  import blk_mem_responder_pkg::*;
#(
  parameter int LATENCY   = 4,
  parameter int MEM_WORDS = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  memory_request_t  mem_req,
  output memory_response_t mem_resp,
  output logic             err
);

  localparam int NUM_BLOCKS = MEM_WORDS / BLOCK_SIZE;
  localparam int IDX_WIDTH  = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int CNT_WIDTH  = 4;

  // Block index of a word address, wrapping modulo the storage depth.
  function automatic logic [IDX_WIDTH-1:0] idx_of(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] blk;
    blk = (a >> OFFSET_WIDTH) % ADDR_WIDTH'(NUM_BLOCKS);
    return blk[IDX_WIDTH-1:0];
  endfunction

  blk_mem_state_t        state_reg, state_next;
  logic [CNT_WIDTH-1:0]  count_reg, count_next;
  logic [ADDR_WIDTH-1:0] base_reg;
  logic                  rw_reg;
  block_t                wdata_reg;
  logic                  ack_reg;
  block_t                resp_data_reg;

  logic                  accept;
  logic                  commit;
  logic                  write_ok;
  block_t                commit_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [IDX_WIDTH-1:0]  mem_idx;
  block_t                mem_rdata;

  // Next-state logic: accept in idle, count down in wait, one-cycle ack.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    accept     = 1'b0;
    commit     = 1'b0;
    unique case (state_reg)
      bm_idle: begin
        if (mem_req.cs) begin
          accept     = 1'b1;
          count_next = CNT_WIDTH'(LATENCY - 1);
          state_next = bm_wait;
        end
      end
      bm_wait: begin
        if (count_reg == '0) begin
          commit     = 1'b1;
          state_next = bm_ack;
        end else begin
          count_next = count_reg - 1'b1;
        end
      end
      bm_ack: begin
        state_next = bm_idle;
      end
      default: begin
        state_next = bm_idle;
      end
    endcase
  end

  // State, counter, ack and response data registers; reset wins over a
  // same-cycle request and aborts an in-flight one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= bm_idle;
      count_reg     <= '0;
      ack_reg       <= 1'b0;
      resp_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      ack_reg   <= commit;
      if (commit && !rw_reg) begin
        resp_data_reg <= commit_rdata;
      end
    end
  end

  // Request latches; only meaningful after an accept, so no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      base_reg  <= block_base(mem_req.addr);
      rw_reg    <= mem_req.rw;
      wdata_reg <= mem_req.data;
    end
  end

`ifdef BLK_MEM_RANGE_CHECK_EN
  logic [ADDR_WIDTH:0] req_end;
  logic                req_oor;
  logic                oor_reg;
  logic                err_reg;

  // Block end one past its last word; out of range when beyond the storage.
  assign req_end = {1'b0, block_base(mem_req.addr)} + (ADDR_WIDTH+1)'(BLOCK_SIZE);
  assign req_oor = req_end > (ADDR_WIDTH+1)'(MEM_WORDS);

  // Capture the range verdict alongside the rest of the request.
  always_ff @(posedge clk) begin
    if (accept) begin
      oor_reg <= req_oor;
    end
  end

  // Sticky error, raised when an out-of-range request completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (commit && oor_reg) begin
      err_reg <= 1'b1;
    end
  end

  assign write_ok     = ~oor_reg;
  assign commit_rdata = oor_reg ? '1 : mem_rdata;
  assign err          = err_reg;
`else
  assign write_ok     = 1'b1;
  assign commit_rdata = mem_rdata;
  assign err          = 1'b0;
`endif

  // The storage read is issued on the accept edge from the live request;
  // nothing else can write the block before completion, so the registered
  // data is still current when it is copied out on the commit edge. This
  // keeps LATENCY=1 working with a registered-read array.
  assign mem_we  = commit & rw_reg & write_ok & ~rst;
  assign mem_en  = (accept & ~rst) | mem_we;
  assign mem_idx = (state_reg == bm_wait) ? idx_of(base_reg) : idx_of(mem_req.addr);

  blk_mem_array #(
    .DEPTH_WORDS (MEM_WORDS)
  ) u_array (
    .clk     (clk),
    .en      (mem_en),
    .we      (mem_we),
    .blk_idx (mem_idx),
    .wdata   (wdata_reg),
    .rdata   (mem_rdata)
  );

  assign mem_resp.ack  = ack_reg;
  assign mem_resp.data = resp_data_reg;

endmodule

// File: doc/blk_mem_responder.md
BLK_MEM_RESPONDER -- requirements
Module: blk_mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4: cycles from request accept to ack, legal range 1..15.
REQ-002 SHALL have parameter MEM_WORDS, default 4096: storage depth in words, a multiple of BLOCK_SIZE.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port mem_req, input, memory_request_t: block request from the cache (addr, cs, rw, data[BLOCK_SIZE]).
REQ-006 SHALL have port mem_resp, output, memory_response_t: ack and data[BLOCK_SIZE], registered.
REQ-007 SHALL have port err, output, 1 bit: sticky out-of-range flag, registered.

Function
REQ-008 SHALL treat addr as a word address; block base = addr with OFFSET_WIDTH LSBs cleared.
REQ-009 SHALL implement an FSM with states IDLE, WAIT and ACK.
REQ-010 In IDLE with cs=1, SHALL accept on that edge: latch base, rw and data[0..BLOCK_SIZE-1], load counter with LATENCY-1, and go to WAIT.
REQ-011 In WAIT, SHALL decrement the counter each cycle; at counter=0 it goes to ACK on the next edge.
REQ-012 In WAIT, SHALL ignore mem_req changes, including cs dropping; the latched request completes.
REQ-013 On the WAIT->ACK edge, a write (rw=1) SHALL store all BLOCK_SIZE words at base..base+BLOCK_SIZE-1.
REQ-014 On the WAIT->ACK edge, a read (rw=0) SHALL load those words into mem_resp.data, word i at data[i].
REQ-015 In ACK, mem_resp.ack SHALL be 1 for exactly one cycle; the FSM returns to IDLE on the next edge unconditionally.
REQ-016 Latency: with the request accepted at edge E, ack SHALL be high in the cycle after edge E+LATENCY.
REQ-017 SHALL not accept a new request during ACK; a request with cs still high in the following IDLE cycle is accepted as new.
REQ-018 mem_resp.data SHALL hold its last read value until the next read completes; writes leave it unchanged.
REQ-019 Outside ACK, mem_resp.ack SHALL be 0.

Reset
REQ-020 rst SHALL force state=IDLE, counter=0, ack=0, mem_resp.data all zero and err=0.
REQ-021 Storage contents SHALL NOT be reset.
REQ-022 rst asserted during WAIT SHALL abort the request: no write is committed and no ack is issued.
REQ-023 rst SHALL take priority over a same-cycle cs.

Configuration
REQ-024 Macro BLK_MEM_RANGE_CHECK_EN: when defined, a request with base+BLOCK_SIZE > MEM_WORDS SHALL complete with normal ack timing, discard writes, return all-ones read data, and set err until rst.
REQ-025 When BLK_MEM_RANGE_CHECK_EN is undefined, the word index SHALL wrap modulo MEM_WORDS, err SHALL be tied 0, and no check logic is generated.

Structure
REQ-026 SHALL add to the shared cache package: typedef blk_mem_state_t {bm_idle, bm_wait, bm_ack} and constants MEM_LATENCY=4 and MEM_WORDS=4096; memory_request_t and memory_response_t are reused unchanged.
REQ-027 SHALL place storage in sub-module blk_mem_array: MEM_WORDS x WORD_WIDTH, one block-wide synchronous read/write port, with no reset.
REQ-028 SHALL keep the FSM, counter, request latches and range check in blk_mem_responder.

Verification
REQ-029 Write then read: write block at addr 0x40 with data {1,2,3,4}, then read addr 0x42 -> each ack occurs 4 cycles after accept, and the read returns {1,2,3,4}.
REQ-030 Input stability: change addr and data and drop cs during WAIT -> the originally latched request completes with a single ack, and the final input values are ignored.
REQ-031 Back-to-back: hold cs=1 through ack with a new addr -> second accept in the IDLE cycle after ACK, no lost or duplicated ack, and ack never high for 2 consecutive cycles.
REQ-032 Reset mid-WAIT: write block 0x80 = {9,9,9,9}, assert rst 2 cycles after accept -> no ack, and a later read of 0x80 returns the prior contents.
REQ-033 With BLK_MEM_RANGE_CHECK_EN: read addr MEM_WORDS -> ack after LATENCY, data all 0xFFFFFFFF, err=1 and held until rst.
REQ-034 Parameter sweep: LATENCY=1 and LATENCY=15 -> measured accept-to-ack distance equals LATENCY in both.
